// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer that owns the architectural PC.
// Optional MISALIGN_TRAP_EN: misaligned next_pc traps to HALT instead of being force-aligned.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic [2:0]  next_pc_sel,
  input  logic        brch_taken,
  input  logic [31:0] brch_imm,
  input  logic [31:0] jal_imm,
  input  logic [31:0] rf_target,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        exec_en,
  output logic        wb_en,
  output logic        retire,
  output logic        fetch_err
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap,
  output logic [31:0] trap_pc
`endif
);

  // next_pc_sel encodings shared with the decoder
  localparam logic [2:0] PC_FROM_PC_PLUS_4 = 3'd0;
  localparam logic [2:0] PC_PLUS_BRCH_IMM  = 3'd1;
  localparam logic [2:0] PC_PLUS_JAL_IMM   = 3'd2;
  localparam logic [2:0] NEXT_PC_FROM_RF   = 3'd3;

  localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  to_cnt;
  logic [31:0] pc_plus4, sel_pc, next_pc;

  assign pc_plus4  = pc + 32'd4;
  assign link_addr = pc_plus4;
  assign imem_addr = pc;

  always_comb begin
    sel_pc = pc_plus4;
    case (next_pc_sel)
      PC_FROM_PC_PLUS_4: sel_pc = pc_plus4;
      PC_PLUS_BRCH_IMM:  sel_pc = brch_taken ? (pc + brch_imm) : pc_plus4;
      PC_PLUS_JAL_IMM:   sel_pc = pc + jal_imm;
      NEXT_PC_FROM_RF:   sel_pc = {rf_target[31:1], 1'b0};
      default:           sel_pc = pc_plus4;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  assign next_pc  = sel_pc;
  assign misalign = |sel_pc[1:0];
`else
  assign next_pc = sel_pc & ~32'h3;
`endif

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    exec_en   = 1'b0;
    wb_en     = 1'b0;
    retire    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign_trap = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)              state_nxt = S_DECODE;
        else if (to_cnt == TO_LAST) state_nxt = S_HALT;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        exec_en   = 1'b1;
        state_nxt = S_WB;
      end
      S_WB: begin
        wb_en = 1'b1;
`ifdef MISALIGN_TRAP_EN
        if (misalign) begin
          misalign_trap = 1'b1;
          state_nxt     = S_HALT;
        end else begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
`else
        retire    = 1'b1;
        state_nxt = S_FETCH;
`endif
      end
      default: state_nxt = S_HALT;
    endcase
    // state already reads FETCH while rst is still held; keep the bus quiet
    if (rst) begin
      imem_req = 1'b0;
      exec_en  = 1'b0;
      wb_en    = 1'b0;
      retire   = 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_trap = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      inst      <= NOP;
      fetch_err <= 1'b0;
      to_cnt    <= 8'd0;
`ifdef MISALIGN_TRAP_EN
      trap_pc   <= 32'd0;
`endif
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && !imem_ack && to_cnt != TO_LAST) to_cnt <= to_cnt + 8'd1;
      else                                                   to_cnt <= 8'd0;
      if (state == S_FETCH && imem_ack) inst <= imem_rdata;
      if (state == S_FETCH && !imem_ack && to_cnt == TO_LAST) fetch_err <= 1'b1;
      if (retire) pc <= next_pc;
`ifdef MISALIGN_TRAP_EN
      if (misalign_trap) trap_pc <= next_pc;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + randomized bench for pc_sequencer; expected PCs come from a plain arithmetic model.
module tb_pc_sequencer;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata, inst;
  logic [2:0]  next_pc_sel;
  logic        brch_taken;
  logic [31:0] brch_imm, jal_imm, rf_target, pc, link_addr;
  logic        exec_en, wb_en, retire, fetch_err;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] trap_pc;
`endif

  int errs   = 0;
  int checks = 0;
  logic [31:0] exp_pc;
  logic        halted;

  pc_sequencer #(.RESET_PC(32'h0), .FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .next_pc_sel(next_pc_sel), .brch_taken(brch_taken),
    .brch_imm(brch_imm), .jal_imm(jal_imm), .rf_target(rf_target),
    .pc(pc), .link_addr(link_addr), .exec_en(exec_en), .wb_en(wb_en),
    .retire(retire), .fetch_err(fetch_err)
`ifdef MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap), .trap_pc(trap_pc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural next-PC rule, before any alignment handling
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [2:0] sel,
      input logic tk, input logic [31:0] bi, input logic [31:0] ji, input logic [31:0] rt);
    case (sel)
      3'd1:    return tk ? p + bi : p + 32'd4;
      3'd2:    return p + ji;
      3'd3:    return rt - (rt % 2);
      default: return p + 32'd4;
    endcase
  endfunction

  task automatic do_reset(input logic ack_pending);
    rst = 1'b1; imem_ack = ack_pending; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_inst", inst, 32'h0000_0013);
      chk("rst_err", fetch_err, 1'b0);
      chk("rst_strobes", {exec_en, wb_en, retire}, 3'b000);
    end
    rst = 1'b0; imem_ack = 1'b0;
    #1;
    chk("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, 32'h0);
    exp_pc = 32'h0;
    halted = 1'b0;
  endtask

  // One instruction starting at a FETCH cycle; w = cycles of ack delay
  task automatic do_instr(input int w, input logic [2:0] sel, input logic tk,
      input logic [31:0] bi, input logic [31:0] ji, input logic [31:0] rt);
    logic [31:0] rd, tgt;
    rd = $urandom;
    for (int i = 0; i < w; i++) begin
      chk("wait_req", imem_req, 1'b1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_exec", exec_en, 1'b0);
      imem_ack = 1'b0;
      @(negedge clk);
    end
    chk("fetch_req", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, exp_pc);
    imem_ack = 1'b1; imem_rdata = rd;
    @(negedge clk);
    chk("dec_inst", inst, rd);
    chk("dec_req", imem_req, 1'b0);
    chk("dec_exec", exec_en, 1'b0);
    imem_rdata = ~rd;  // ack still high: must be ignored outside FETCH
    next_pc_sel = sel; brch_taken = tk; brch_imm = bi; jal_imm = ji; rf_target = rt;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("ex_exec", exec_en, 1'b1);
    chk("ex_wb", {wb_en, retire}, 2'b00);
    chk("ex_link", link_addr, exp_pc + 32'd4);
    chk("ex_inst", inst, rd);
    @(negedge clk);
    chk("wb_wb", wb_en, 1'b1);
    chk("wb_exec", exec_en, 1'b0);
    tgt = ref_next(exp_pc, sel, tk, bi, ji, rt);
`ifdef MISALIGN_TRAP_EN
    if (tgt[1:0] != 2'b00) begin
      chk("trap_retire", retire, 1'b0);
      chk("trap_pulse", misalign_trap, 1'b1);
      @(negedge clk);
      chk("trap_pc", trap_pc, tgt);
      chk("trap_pc_hold", pc, exp_pc);
      chk("trap_halt_req", imem_req, 1'b0);
      chk("trap_once", misalign_trap, 1'b0);
      halted = 1'b1;
      return;
    end
    chk("no_trap", misalign_trap, 1'b0);
`else
    tgt = {tgt[31:2], 2'b00};
`endif
    chk("wb_retire", retire, 1'b1);
    @(negedge clk);
    exp_pc = tgt;
    chk("next_pc", pc, exp_pc);
    chk("retire_pulse", retire, 1'b0);
    chk("refetch_req", imem_req, 1'b1);
  endtask

  initial begin
    imem_ack = 1'b0; imem_rdata = 32'h0; next_pc_sel = 3'd0; brch_taken = 1'b0;
    brch_imm = 32'h0; jal_imm = 32'h0; rf_target = 32'h0; exp_pc = 32'h0; halted = 1'b0;

    do_reset(1'b0);
    // sequential ADDI, immediate and delayed ack
    do_instr(0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    do_instr(3, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    // branches at 0x10 (reached by JALR with bit 0 set)
    do_instr(0, 3'd3, 1'b0, 32'h0, 32'h0, 32'h11);
    do_instr(0, 3'd1, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h0);
    chk("beq_taken", pc, 32'h8);
    do_instr(0, 3'd3, 1'b0, 32'h0, 32'h0, 32'h10);
    do_instr(1, 3'd1, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0);
    chk("beq_not_taken", pc, 32'h14);
    // JAL wrap at top of address space
    do_instr(0, 3'd3, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
    do_instr(0, 3'd2, 1'b0, 32'h0, 32'h8, 32'h0);
    chk("jal_wrap", pc, 32'h4);
    // undefined selector encodings fall back to pc+4
    do_instr(0, 3'd5, 1'b1, 32'h40, 32'h80, 32'h200);
    do_instr(0, 3'd7, 1'b1, 32'h40, 32'h80, 32'h200);
    // JALR to misaligned targets
    do_instr(0, 3'd3, 1'b0, 32'h0, 32'h0, 32'h101);
    chk("jalr_101", pc, 32'h100);
    do_instr(0, 3'd3, 1'b0, 32'h0, 32'h0, 32'h103);
    if (halted) do_reset(1'b0);
    else chk("jalr_103", pc, 32'h100);

    // randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      logic [31:0] bi, ji, rt;
      bi = $urandom; ji = $urandom; rt = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        bi[1:0] = 2'b00; ji[1:0] = 2'b00; rt[1] = 1'b0;
      end
      do_instr(int'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 1'($urandom),
               bi, ji, rt);
      if (halted) do_reset(1'b0);
    end

    // fetch timeout
    imem_ack = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk("to_req", imem_req, 1'b1);
      chk("to_err_low", fetch_err, 1'b0);
      @(negedge clk);
    end
    chk("to_err", fetch_err, 1'b1);
    chk("to_halt_req", imem_req, 1'b0);
    imem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("halt_req", imem_req, 1'b0);
    chk("halt_strobes", {exec_en, wb_en, retire}, 3'b000);
    chk("halt_err_sticky", fetch_err, 1'b1);
    imem_ack = 1'b0;

    // reset out of HALT, then reset mid-FETCH with ack pending
    do_reset(1'b0);
    do_instr(0, 3'd2, 1'b0, 32'h0, 32'h20, 32'h0);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midfetch_req", imem_req, 1'b1);
    do_reset(1'b1);
    do_instr(2, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("after_reset_pc", pc, 32'h4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle instruction sequencer for the single-issue RISC-V core.
- Owns the architectural PC and fetches from instruction memory over a req/ack handshake.
- Holds the fetched word for the decoder and consumes the decoder's next_pc_sel to compute and commit the next PC.
- Pulses the execute and writeback strobes that step the datapath one instruction at a time.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FETCH_TIMEOUT, 16, max cycles FETCH waits for imem_ack before error; range 1..255.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
imem_req  out  1  fetch request; held until ack.
imem_addr  out  32  fetch address; equals pc while imem_req=1.
imem_ack  in  1  memory has accepted the request; imem_rdata is valid this cycle.
imem_rdata  in  32  fetched instruction word.
inst  out  32  registered instruction driven to the decoder.
next_pc_sel  in  3  from decoder; uses the decode.vh encodings.
brch_taken  in  1  branch condition from ALU compare; sampled in WRITEBACK.
brch_imm  in  32  sign-extended B-type offset.
jal_imm  in  32  sign-extended J-type offset.
rf_target  in  32  rs1+imm for JALR.
pc  out  32  current instruction address.
link_addr  out  32  pc+4, for the JAL/JALR rd write.
exec_en  out  1  one-cycle pulse in EXECUTE.
wb_en  out  1  one-cycle pulse in WRITEBACK.
retire  out  1  one-cycle pulse when the PC commits.
fetch_err  out  1  sticky; fetch timed out.

Behaviour:
- Reset (synchronous, any state):
  - pc=RESET_PC; inst=32'h0000_0013 (NOP).
  - fetch_err=0; timeout counter=0.
  - All strobes and imem_req are 0.
  - State becomes FETCH; imem_req=1 on the first cycle after rst deasserts.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On imem_ack: latch inst<=imem_rdata, then go to DECODE.
  - Otherwise increment the counter. On reaching FETCH_TIMEOUT: fetch_err<=1, go to HALT.
  - Counter clears on leaving FETCH.
- DECODE: one cycle; decoder settles from inst; then EXECUTE.
- EXECUTE: exec_en=1 for one cycle; then WRITEBACK.
- WRITEBACK: wb_en=1 and retire=1; pc<=next_pc; go to FETCH. next_pc is selected by next_pc_sel:
  - PC_FROM_PC_PLUS_4 -> pc+4.
  - PC_PLUS_BRCH_IMM -> pc+brch_imm if brch_taken, else pc+4.
  - PC_PLUS_JAL_IMM -> pc+jal_imm.
  - NEXT_PC_FROM_RF -> {rf_target[31:1],1'b0}.
  - Any other encoding -> pc+4.
- HALT: all strobes 0, imem_req=0; only rst exits.
- Arithmetic: all additions are 32-bit modulo 2^32; wrap-around is silent.
- link_addr = pc+4, combinational from pc.
- Latency: 4 cycles per instruction when ack arrives in the first FETCH cycle; +1 per wait cycle.
- imem_ack outside FETCH is ignored.
- imem_rdata is sampled only on the ack cycle.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Enabled:
  - In WRITEBACK, if the selected next_pc[1:0]!=0 (after the JALR bit-0 clear), pc is not updated and retire=0.
  - misalign_trap (extra out, 1 bit) pulses and trap_pc (extra out, 32 bits) latches the offending target.
  - State goes to HALT.
- Disabled: next_pc[1:0] forced to 2'b00; no extra ports.

Test Plan:
1. rst=1 for 2 cycles, then 0 -> during reset pc=0, imem_req=0, inst=0x00000013; cycle after release imem_req=1, imem_addr=0x0.
2. ADDI at 0x0, ack in first FETCH cycle, sel=PC_FROM_PC_PLUS_4 -> exec_en, wb_en, retire each single pulses; retire 4 cycles after request; pc=0x4. Repeat with ack delayed 3 cycles -> retire 7 cycles after request.
3. BEQ at 0x10, brch_imm=0xFFFFFFF8 -> brch_taken=1 gives pc=0x8; brch_taken=0 gives pc=0x14.
4. JAL at 0xFFFFFFFC, jal_imm=0x8 -> link_addr=0x0 during execute; pc=0x4 after wrap.
5. JALR, rf_target=0x103 -> macro on: misalign_trap pulses, trap_pc=0x102, pc unchanged, HALT. Macro off: pc=0x100. rf_target=0x101 -> pc=0x100 in both builds.
6. Ack withheld FETCH_TIMEOUT cycles -> fetch_err=1, imem_req=0, HALT. Assert rst mid-FETCH (ack pending) -> next cycle pc=RESET_PC, fetch_err=0, fresh FETCH.
